// File: rtl/life_pkg.sv
// Shared Game-of-Life definitions: grid defaults, engine state encoding, renderer colours
// and the small neighbour-count helper used by the row calculator.
package life_pkg;

  localparam int ROWS_DEF  = 15;
  localparam int COLS_DEF  = 20;
  localparam int GEN_W_DEF = 16;
  localparam int ROW_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // 24-bit RGB colours shared with the sprite-matrix renderer.
  localparam logic [23:0] COLOUR_ALIVE = 24'hF0F0F0;
  localparam logic [23:0] COLOUR_DEAD  = 24'h101010;
  localparam logic [23:0] COLOUR_GRID  = 24'h303030;

  function automatic logic [3:0] count3(input logic [2:0] bits);
    return {3'b000, bits[0]} + {3'b000, bits[1]} + {3'b000, bits[2]};
  endfunction

endpackage

// File: rtl/life_row_calc.sv
// Combinational B3/S23 next-state for one row from its upper, own and lower row words.
// Zero latency, no flow control; edge columns are dead or wrapped depending on WRAP.
module life_row_calc
  import life_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter bit WRAP = 1'b0
) (
  input  logic [COLS-1:0] up,
  input  logic [COLS-1:0] mid,
  input  logic [COLS-1:0] dn,
  output logic [COLS-1:0] nxt
);

  // Each word is extended by one column on both sides: bit 0 is column -1,
  // bit COLS+1 is column COLS, so cell c sits at extended bit c+1.
  logic [COLS+1:0] up_x;
  logic [COLS+1:0] mid_x;
  logic [COLS+1:0] dn_x;

  always_comb begin
    up_x  = {(WRAP ? up[0]  : 1'b0), up,  (WRAP ? up[COLS-1]  : 1'b0)};
    mid_x = {(WRAP ? mid[0] : 1'b0), mid, (WRAP ? mid[COLS-1] : 1'b0)};
    dn_x  = {(WRAP ? dn[0]  : 1'b0), dn,  (WRAP ? dn[COLS-1]  : 1'b0)};
  end

  always_comb begin
    logic [3:0] n;
    n   = '0;
    nxt = '0;
    for (int c = 0; c < COLS; c++) begin
      n = count3(up_x[c +: 3])
        + count3(dn_x[c +: 3])
        + count3({mid_x[c+2], 1'b0, mid_x[c]});
      nxt[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: holds the current grid for the renderer and steps it one row per cycle.
// start-to-done is ROWS+2 cycles; start/ld_en while busy are dropped, rd_data is always live.
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter bit WRAP  = 1'b0,
  parameter int GEN_W = GEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 ld_en,
  input  logic [ROW_IDX_W-1:0] ld_row,
  input  logic [COLS-1:0]      ld_data,
  input  logic [ROW_IDX_W-1:0] rd_row,
  output logic [COLS-1:0]      rd_data,
  output logic [GEN_W-1:0]     gen_count
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

  state_t               state;
  state_t               state_d;
  logic [ROW_IDX_W-1:0] ptr;
  logic [ROW_IDX_W-1:0] ptr_d;
  logic                 start_pend;
  logic                 start_pend_d;
  logic                 load_we;
  logic                 calc_we;
  logic                 commit;

  logic [COLS-1:0] cur      [ROWS];
  logic [COLS-1:0] nxt_grid [ROWS];

  logic [COLS-1:0] up_row;
  logic [COLS-1:0] mid_row;
  logic [COLS-1:0] dn_row;
  logic [COLS-1:0] calc_row;

  // A sampled start spends one IDLE cycle pending before CALC begins; this
  // aligns the commit so the new grid appears ROWS+2 edges after start.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    start_pend_d = start_pend;
    load_we      = 1'b0;
    calc_we      = 1'b0;
    commit       = 1'b0;
    unique case (state)
      IDLE: begin
        load_we = ld_en && (ld_row <= LAST_ROW);
        if (start_pend) begin
          state_d      = CALC;
          ptr_d        = '0;
          start_pend_d = 1'b0;
        end else if (start && !ld_en) begin
          start_pend_d = 1'b1;
        end
      end
      CALC: begin
        calc_we = 1'b1;
        if (ptr == LAST_ROW) begin
          state_d = COMMIT;
        end else begin
          ptr_d = ptr + ROW_IDX_W'(1);
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mid_row = cur[ptr];
    up_row  = (ptr == '0)       ? (WRAP ? cur[LAST_ROW] : '0) : cur[ptr - ROW_IDX_W'(1)];
    dn_row  = (ptr == LAST_ROW) ? (WRAP ? cur[0]        : '0) : cur[ptr + ROW_IDX_W'(1)];
  end

  life_row_calc #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row_calc (
    .up  (up_row),
    .mid (mid_row),
    .dn  (dn_row),
    .nxt (calc_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      start_pend <= 1'b0;
      done       <= 1'b0;
      gen_count  <= '0;
      for (int r = 0; r < ROWS; r++) begin
        cur[r]      <= '0;
        nxt_grid[r] <= '0;
      end
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      start_pend <= start_pend_d;
      done       <= commit;
      if (load_we) begin
        cur[ld_row] <= ld_data;
      end
      if (calc_we) begin
        nxt_grid[ptr] <= calc_row;
      end
      if (commit) begin
        for (int r = 0; r < ROWS; r++) begin
          cur[r] <= nxt_grid[r];
        end
        gen_count <= gen_count + GEN_W'(1);
      end
    end
  end

  assign busy    = (state == CALC) || (state == COMMIT);
  assign rd_data = (rd_row <= LAST_ROW) ? cur[rd_row] : '0;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench: a flat-edge and a toroidal engine driven side by side with hand-computed grids.
module tb_life_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ld_en;
  logic [3:0]  ld_row;
  logic [19:0] ld_data;
  logic [3:0]  rd_row;
  logic        busy0, done0, busy1, done1;
  logic [19:0] rd0, rd1;
  logic [15:0] gen0, gen1;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp0 [16];
  logic [19:0] exp1 [16];

  always #5 clk = ~clk;

  life_engine #(.ROWS(15), .COLS(20), .WRAP(1'b0), .GEN_W(16)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy0),
    .done      (done0),
    .ld_en     (ld_en),
    .ld_row    (ld_row),
    .ld_data   (ld_data),
    .rd_row    (rd_row),
    .rd_data   (rd0),
    .gen_count (gen0)
  );

  life_engine #(.ROWS(15), .COLS(20), .WRAP(1'b1), .GEN_W(16)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy1),
    .done      (done1),
    .ld_en     (ld_en),
    .ld_row    (ld_row),
    .ld_data   (ld_data),
    .rd_row    (rd_row),
    .rd_data   (rd1),
    .gen_count (gen1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr_exp();
    for (int r = 0; r < 16; r++) begin
      exp0[r] = '0;
      exp1[r] = '0;
    end
  endtask

  task automatic chk_grid(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_row = 4'(r);
      #1;
      chk($sformatf("%s wrap0 row%0d", tag, r), 32'(rd0), 32'(exp0[r]));
      chk($sformatf("%s wrap1 row%0d", tag, r), 32'(rd1), 32'(exp1[r]));
    end
  endtask

  task automatic chk_gen(input string tag, input int g);
    chk({tag, " gen0"}, 32'(gen0), 32'(g));
    chk({tag, " gen1"}, 32'(gen1), 32'(g));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    ld_en   = 1'b0;
    ld_row  = '0;
    ld_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] r, input logic [19:0] d);
    ld_en   = 1'b1;
    ld_row  = r;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Pulses start and waits (bounded) for done; inject=1 pokes start and a
  // row-7 load into the 5th CALC cycle.
  task automatic step(input string tag, input bit inject);
    int cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inject && cyc == 5) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_row  = 4'd7;
        ld_data = '1;
      end else if (inject && cyc == 6) begin
        start = 1'b0;
        ld_en = 1'b0;
      end
    end
    chk({tag, " latency"}, 32'(cyc), 32'd17);
    chk({tag, " done1"}, 32'(done1), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, 32'(done0), 32'd0);
  endtask

  initial begin
    logic busy_seen;
    rd_row = '0;
    do_reset();

    // Reset state
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk_gen("reset", 0);
    clr_exp();
    chk_grid("reset");

    // Blinker oscillates with period 2
    load(4'd7, 20'h00700);
    step("blink1", 1'b0);
    clr_exp();
    for (int r = 6; r <= 8; r++) begin
      exp0[r] = 20'h00200;
      exp1[r] = 20'h00200;
    end
    chk_grid("blink1");
    chk_gen("blink1", 1);
    step("blink2", 1'b0);
    clr_exp();
    exp0[7] = 20'h00700;
    exp1[7] = 20'h00700;
    chk_grid("blink2");
    chk_gen("blink2", 2);

    // Block still life against column 0
    do_reset();
    load(4'd3, 20'h00003);
    load(4'd4, 20'h00003);
    for (int i = 0; i < 3; i++) step("block", 1'b0);
    clr_exp();
    exp0[3] = 20'h00003; exp0[4] = 20'h00003;
    exp1[3] = 20'h00003; exp1[4] = 20'h00003;
    chk_grid("block");
    chk_gen("block", 3);

    // Row wrap (row 0 blinker) and column wrap (row 5 blinker centred on col 0)
    do_reset();
    load(4'd0, 20'h00007);
    load(4'd5, 20'h80003);
    step("edge", 1'b0);
    clr_exp();
    exp0[0] = 20'h00002; exp0[1] = 20'h00002;
    exp1[14] = 20'h00002; exp1[0] = 20'h00002; exp1[1] = 20'h00002;
    exp1[4] = 20'h00001; exp1[5] = 20'h00001; exp1[6] = 20'h00001;
    chk_grid("edge");

    // Protocol: start/ld_en during CALC are ignored
    do_reset();
    load(4'd7, 20'h00700);
    step("proto", 1'b1);
    clr_exp();
    for (int r = 6; r <= 8; r++) begin
      exp0[r] = 20'h00200;
      exp1[r] = 20'h00200;
    end
    chk_grid("proto calc");
    busy_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1 busy_seen = busy_seen | busy0 | busy1;
    end
    chk("proto no extra step busy", 32'(busy_seen), 32'd0);
    chk_gen("proto", 1);

    // start together with ld_en in IDLE: load wins, no step
    start   = 1'b1;
    ld_en   = 1'b1;
    ld_row  = 4'd2;
    ld_data = 20'h12345;
    @(posedge clk);
    #1;
    start = 1'b0;
    ld_en = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 busy_seen = busy_seen | busy0 | busy1;
    end
    chk("start+load busy", 32'(busy_seen), 32'd0);
    exp0[2] = 20'h12345;
    exp1[2] = 20'h12345;
    chk_grid("start+load");
    chk_gen("start+load", 1);

    // Reset in the 5th CALC cycle aborts the step
    do_reset();
    load(4'd7, 20'h00700);
    step("pre-abort", 1'b0);
    chk_gen("pre-abort", 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort mid busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort done", 32'(done0), 32'd0);
    chk_gen("abort", 0);
    clr_exp();
    chk_grid("abort");

    // Out-of-range load is dropped; rd_row 15 reads 0
    load(4'd14, 20'hABCDE);
    load(4'd15, 20'hFFFFF);
    clr_exp();
    exp0[14] = 20'hABCDE;
    exp1[14] = 20'hABCDE;
    chk_grid("range");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
